// File: rtl/riscv_ifetch.sv
// -----------------------------------------------------------------------------
// riscv_ifetch
//
// Instruction fetch unit. Issues word-aligned fetch requests to instruction
// memory, buffers in-order responses in a DEPTH-entry FIFO tagged with their
// PC, and hands them to the core. A redirect flushes the buffer and retargets
// fetching. Responses still in flight at that point are counted and dropped
// when they return. A misaligned redirect target parks the unit in an error
// state until an aligned redirect arrives.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     buffer entries and maximum requests in flight (2, 4 or 8)
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   imem_req_valid/ready/addr         fetch request channel
//   imem_rsp_valid/data               in-order read data, always accepted
//   instr_valid/ready/data/pc         instruction channel to the core
//   redirect_valid/pc                 branch/jump retarget from the core
//   fetch_err                         sticky misaligned-target flag
// -----------------------------------------------------------------------------
module riscv_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, ERR} state_e;

    state_e        state_q;
    logic          fetch_err_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];

    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CW:0]   in_use;
    logic          misaligned;

    // Credit covers both requests in flight and entries already buffered, so
    // every response is guaranteed a FIFO slot. A pop in the same cycle does
    // not free credit, which keeps the request path independent of instr_ready.
    assign in_use         = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid = (state_q == RUN) && !redirect_valid
                            && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    assign instr_valid    = (state_q != ERR) && (count_q != '0);
    assign instr_data     = fifo_data_q[rd_ptr_q];
    assign instr_pc       = fifo_pc_q[rd_ptr_q];
    assign fetch_err      = fetch_err_q;

    assign misaligned     = (redirect_pc[1:0] != 2'b00);
    assign req_fire       = imem_req_valid && imem_req_ready;
    // A redirect wins over pop and push in the same cycle.
    assign pop            = instr_valid && instr_ready && !redirect_valid;
    assign push           = imem_rsp_valid && !redirect_valid
                            && (state_q == RUN) && (discard_q == '0);

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can
        // leave it unassigned and infer a latch.
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc;
            rsp_pc_d      = redirect_pc;
            // Everything still in flight after this cycle's response belongs
            // to the old stream; a response arriving now is dropped outright.
            outstanding_d = outstanding_q - CW'(imem_rsp_valid);
            discard_d     = outstanding_q - CW'(imem_rsp_valid);
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_err_q   <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;

            case (state_q)
                BOOT: begin
                    // A misaligned target arriving in BOOT must not reach RUN.
                    if (redirect_valid && misaligned) begin
                        state_q     <= ERR;
                        fetch_err_q <= 1'b1;
                    end else begin
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (redirect_valid && misaligned) begin
                        state_q     <= ERR;
                        fetch_err_q <= 1'b1;
                    end
                end
                ERR: begin
                    if (redirect_valid && !misaligned) begin
                        state_q     <= RUN;
                        fetch_err_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= BOOT;
                    fetch_err_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: buffer storage has no reset; count_q gates every read, so stale
    // contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
            fifo_data_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_riscv_ifetch.sv
// -----------------------------------------------------------------------------
// tb_riscv_ifetch
//
// Self-checking bench for riscv_ifetch. A queue-based memory model answers
// accepted requests in order after a chosen latency. The expected instruction
// stream is just "consecutive PCs from the last redirect target, each carrying
// the memory word at that PC", and requests must walk the same sequence.
// -----------------------------------------------------------------------------
module tb_riscv_ifetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    riscv_ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          cyc       = 0;
    int          last_due  = 0;
    int          lat_lo    = 1;
    int          lat_hi    = 1;
    int          n_err     = 0;
    int          n_chk     = 0;
    int          n_pop     = 0;
    int          n_req     = 0;
    logic [31:0] exp_req_pc;
    logic [31:0] exp_instr_pc;
    bit          err_model;
    bit          chk_iv0;
    bit          hold_q;
    logic [31:0] hold_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds reset for two edges, checks reset outputs, the BOOT cycle, and the
    // first request in the second cycle after reset falls. Ends in that cycle.
    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        cyc += 2;
        pend.delete();
        last_due     = cyc;
        exp_req_pc   = RESET_PC;
        exp_instr_pc = RESET_PC;
        err_model    = 1'b0;
        chk_iv0      = 1'b0;
        hold_q       = 1'b0;
        check("rst_req_valid",   32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid),    32'd0);
        check("rst_fetch_err",   32'(fetch_err),      32'd0);
        rst = 1'b0;
        #1;
        check("boot_no_req", 32'(imem_req_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        cyc++;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr",  imem_req_addr,       RESET_PC);
    endtask

    // One clock cycle: drive inputs, present any due memory response, check
    // the observable outputs against the stream model, then advance.
    task automatic step(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
        bit rsp;
        bit hs;
        bit pop;
        int due;
        imem_req_ready = rdy;
        instr_ready    = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp = (pend.size() != 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom;
        #1;
        check("fetch_err", 32'(fetch_err), 32'(err_model));
        if (err_model) begin
            check("err_no_req",   32'(imem_req_valid), 32'd0);
            check("err_no_instr", 32'(instr_valid),    32'd0);
        end
        if (chk_iv0) check("iv_after_redirect", 32'(instr_valid), 32'd0);
        if (redir)   check("redirect_no_req",   32'(imem_req_valid), 32'd0);
        if (hold_q && !redir) begin
            check("req_held_valid", 32'(imem_req_valid), 32'd1);
            check("req_held_addr",  imem_req_addr,       hold_addr);
        end
        hs  = imem_req_valid && rdy;
        pop = instr_valid && irdy && !redir;
        if (pop) begin
            check("instr_pc",   instr_pc,   exp_instr_pc);
            check("instr_data", instr_data, mem_word(exp_instr_pc));
            exp_instr_pc += 32'd4;
            n_pop++;
        end
        if (rsp) void'(pend.pop_front());
        if (hs) begin
            check("req_addr", imem_req_addr, exp_req_pc);
            exp_req_pc += 32'd4;
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{imem_req_addr, due});
            n_req++;
        end
        check("inflight_le_depth", 32'(pend.size() <= DEPTH), 32'd1);
        hold_q    = imem_req_valid && !rdy && !redir;
        hold_addr = imem_req_addr;
        chk_iv0   = redir;
        if (redir) begin
            exp_req_pc   = rpc;
            exp_instr_pc = rpc;
            err_model    = (rpc[1:0] != 2'b00);
        end
        @(posedge clk); @(negedge clk);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int unsigned roll;
        logic [31:0] tgt;

        // Streaming: ready memory, 1-cycle latency, core always ready.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h0);
        base = n_pop;
        for (int i = 0; i < 20; i++) step(1, 1, 0, 32'h0);
        check("stream_throughput", 32'(n_pop - base), 32'd20);

        // Core stalled: exactly DEPTH requests, then the request line drops.
        do_reset();
        base = n_req;
        for (int i = 0; i < 12; i++) step(1, 0, 0, 32'h0);
        check("stall_req_count", 32'(n_req - base), 32'(DEPTH));
        check("stall_req_low",   32'(imem_req_valid), 32'd0);
        check("stall_iv",        32'(instr_valid),    32'd1);
        check("stall_pc_held",   instr_pc,            RESET_PC);

        // Redirect with two responses in flight: both must be dropped.
        do_reset();
        lat_lo = 5; lat_hi = 5;
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        check("two_in_flight", 32'(pend.size()), 32'd2);
        step(1, 0, 1, 32'h0000_0100);
        lat_lo = 1; lat_hi = 1;
        base = n_pop;
        for (int i = 0; i < 15; i++) step(1, 1, 0, 32'h0);
        check("redirect_progress", 32'(n_pop - base > 4), 32'd1);

        // Misaligned target parks in ERR; an aligned target recovers.
        step(1, 1, 1, 32'h0000_0102);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h0);
        step(1, 1, 1, 32'h0000_0200);
        base = n_pop;
        for (int i = 0; i < 10; i++) step(1, 1, 0, 32'h0);
        check("recover_progress", 32'(n_pop - base > 4), 32'd1);

        // Address wrap at the top of the space.
        step(1, 1, 1, 32'hFFFF_FFFC);
        base = n_pop;
        for (int i = 0; i < 10; i++) step(1, 1, 0, 32'h0);
        check("wrap_progress", 32'(n_pop - base > 2), 32'd1);

        // Random traffic with occasional redirects and a reset mid-run.
        lat_lo = 1; lat_hi = 4;
        base = n_pop;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            roll = $urandom_range(199, 0);
            tgt  = $urandom & 32'h000F_FFFC;
            if (roll == 0) tgt[1] = 1'b1;
            step($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 60,
                 roll < 3, tgt);
        end
        // Leave ERR if the last random redirect was misaligned.
        step(1, 1, 1, 32'h0000_0400);
        check("random_progress", 32'(n_pop - base > 300), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_ifetch.md
RISCV_IFETCH -- requirements
Module: riscv_ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, legal 2/4/8: instruction buffer entries and maximum requests in flight.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high; one clock, synchronous and active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  in-order read data valid, at least 1 cycle after its request, always accepted.
REQ-009 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-010 SHALL have port instr_valid  output  1  instruction available to the core.
REQ-011 SHALL have port instr_ready  input  1  core consumes instruction this cycle.
REQ-012 SHALL have port instr_data  output  32  instruction word to the core.
REQ-013 SHALL have port instr_pc  output  32  address of instr_data.
REQ-014 SHALL have port redirect_valid  input  1  core branch/jump redirect.
REQ-015 SHALL have port redirect_pc  input  32  new fetch target.
REQ-016 SHALL have port fetch_err  output  1  sticky misaligned-target flag.

Function
REQ-017 SHALL implement states BOOT, RUN and ERR: BOOT lasts exactly one cycle after reset and goes to RUN; RUN goes to ERR on a redirect with redirect_pc[1:0]!=0; ERR goes to RUN on a redirect with redirect_pc[1:0]==0.
REQ-018 SHALL hold registers fetch_pc (next request), rsp_pc (PC of next expected response), outstanding (0..DEPTH), discard (0..DEPTH) and a DEPTH-entry FIFO of {pc, data}.
REQ-019 SHALL assert imem_req_valid only in RUN, without redirect_valid, and only when outstanding + FIFO count < DEPTH, using current-cycle values with no same-cycle pop credit.
REQ-020 SHALL drive imem_req_addr = fetch_pc, and SHALL hold valid and address stable until imem_req_ready except on a redirect cycle.
REQ-021 SHALL, on request handshake, set fetch_pc += 4 modulo 2^32 (wraps 32'hFFFF_FFFC -> 0) and increment outstanding.
REQ-022 SHALL, on imem_rsp_valid, decrement outstanding; if discard>0 it SHALL drop the data and decrement discard; otherwise it SHALL push {rsp_pc, data} and set rsp_pc += 4.
REQ-023 SHALL give registered latency: a response pushed in cycle N makes instr_valid high in N+1 when the FIFO was empty.
REQ-024 SHALL drive instr_valid = FIFO not empty, and instr_data/instr_pc from the FIFO head; a pop occurs on instr_valid & instr_ready.
REQ-025 SHALL, on a simultaneous push and pop, leave the count unchanged and keep order.
REQ-026 SHALL, on redirect_valid, flush the FIFO, set fetch_pc = rsp_pc = redirect_pc, set discard = outstanding after this cycle's response, suppress the request this cycle, and drop any same-cycle response.
REQ-027 SHALL give redirect priority over pop, push and request in the same cycle; instr_valid SHALL be 0 in the cycle after a redirect.
REQ-028 SHALL, in ERR, set fetch_err=1, instr_valid=0, no requests, and SHALL keep discarding in-flight responses.
REQ-029 SHALL NOT overflow the FIFO, because credit accounting guarantees space.

Reset
REQ-030 SHALL, on rst high at a clock edge, set state BOOT, fetch_pc=rsp_pc=RESET_PC, outstanding=discard=0, FIFO empty, fetch_err=0, imem_req_valid=0, instr_valid=0.
REQ-031 SHALL, on reset mid-operation, abandon in-flight requests; the bench SHALL also reset the memory model.
REQ-032 SHALL raise the first request, addr=RESET_PC, in the second cycle after rst falls.

Verification
REQ-033 SHALL cover: ready=1, 1-cycle memory, instr_ready=1 -> PCs 0,4,8,... one instruction per cycle after fill, data matches memory.
REQ-034 SHALL cover: instr_ready=0 -> exactly DEPTH requests issued, then imem_req_valid=0, instr_pc held at 0.
REQ-035 SHALL cover: redirect to 0x100 with 2 responses in flight -> those 2 dropped, next instr_pc=0x100.
REQ-036 SHALL cover: redirect to 0x102 -> fetch_err=1, no requests; redirect to 0x200 -> fetch_err=0, instr_pc=0x200.
REQ-037 SHALL cover: redirect to 0xFFFF_FFFC -> PCs 0xFFFF_FFFC then 0x0.
REQ-038 SHALL cover: random imem_req_ready/latency/instr_ready -> in-order, gap-free PCs, outstanding never exceeds DEPTH.
